// File: rtl/bin2ascii_word_if.sv
// Handshake and result bundle for the binary-to-ASCII word converter.
// The master presents values; the slave converts them and returns the display word.
interface bin2ascii_word_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  value;
    logic [31:0] word;
    logic        word_valid;
    logic        busy;

    modport master (
        output in_valid,
        output value,
        input  in_ready,
        input  word,
        input  word_valid,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  value,
        output in_ready,
        output word,
        output word_valid,
        output busy
    );
endinterface

// File: rtl/bin2ascii_word.sv
// Iterative double-dabble converter: 8-bit value to right-justified 4-char ASCII word.
// One bit per clock; ten clocks per conversion including accept and format.
module bin2ascii_word #(
    parameter bit SIGNED      = 1'b0,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    bin2ascii_word_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_FMT
    } state_t;

    localparam logic [7:0]  C_SPACE = 8'h20;
    localparam logic [7:0]  C_MINUS = 8'h2D;
    localparam logic [7:0]  C_ZERO  = 8'h30;
    localparam logic [31:0] W_BLANK = 32'h20202020;

    state_t      r_state;
    logic [7:0]  r_mag;
    logic [1:0]  r_h;
    logic [3:0]  r_t;
    logic [3:0]  r_u;
    logic [2:0]  r_cnt;
    logic        r_neg;
    logic [31:0] r_word;
    logic        r_word_valid;

    logic        w_neg_in;
    logic [7:0]  w_mag_in;
    logic [3:0]  w_t_adj;
    logic [3:0]  w_u_adj;
    logic [7:0]  w_hc;
    logic [7:0]  w_tc;
    logic [7:0]  w_uc;
    logic [7:0]  w_sc;
    logic [31:0] w_word;

    assign w_neg_in = SIGNED && bus.value[7];
    assign w_mag_in = w_neg_in ? (~bus.value + 8'd1) : bus.value;

    // Hundreds never exceeds 2, so only tens and units need the +3 step.
    assign w_t_adj = (r_t >= 4'd5) ? r_t + 4'd3 : r_t;
    assign w_u_adj = (r_u >= 4'd5) ? r_u + 4'd3 : r_u;

    assign w_hc = C_ZERO + {6'd0, r_h};
    assign w_tc = C_ZERO + {4'd0, r_t};
    assign w_uc = C_ZERO + {4'd0, r_u};
    assign w_sc = r_neg ? C_MINUS : C_SPACE;

    always_comb begin
        w_word = W_BLANK;
        if (!BLANK_ZEROS) begin
            w_word = {w_sc, w_hc, w_tc, w_uc};
        end else if (r_h != 2'd0) begin
            w_word = {w_sc, w_hc, w_tc, w_uc};
        end else if (r_t != 4'd0) begin
            w_word = {C_SPACE, w_sc, w_tc, w_uc};
        end else begin
            w_word = {C_SPACE, C_SPACE, w_sc, w_uc};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mag        <= 8'd0;
            r_h          <= 2'd0;
            r_t          <= 4'd0;
            r_u          <= 4'd0;
            r_cnt        <= 3'd0;
            r_neg        <= 1'b0;
            r_word       <= W_BLANK;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_neg   <= w_neg_in;
                        r_mag   <= w_mag_in;
                        r_h     <= 2'd0;
                        r_t     <= 4'd0;
                        r_u     <= 4'd0;
                        r_cnt   <= 3'd0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_h, r_t, r_u, r_mag} <=
                        {r_h[0], w_t_adj, w_u_adj, r_mag, 1'b0};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= S_FMT;
                    end
                end
                S_FMT: begin
                    r_word       <= w_word;
                    r_word_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.word       = r_word;
    assign bus.word_valid = r_word_valid;

endmodule

// File: tb/tb_bin2ascii_word.sv
// Randomized bench for bin2ascii_word across three parameter sets.
// Expected words come from an arithmetic decimal-formatting model.
module tb_bin2ascii_word;

    logic       clk;
    logic       reset;
    logic       tb_valid;
    logic [7:0] tb_value;
    int         n_checks;
    int         n_errors;

    bin2ascii_word_if if_u ();
    bin2ascii_word_if if_s ();
    bin2ascii_word_if if_z ();

    assign if_u.in_valid = tb_valid;
    assign if_u.value    = tb_value;
    assign if_s.in_valid = tb_valid;
    assign if_s.value    = tb_value;
    assign if_z.in_valid = tb_valid;
    assign if_z.value    = tb_value;

    bin2ascii_word #(.SIGNED(1'b0), .BLANK_ZEROS(1'b1)) u_uns (
        .clk   (clk),
        .reset (reset),
        .bus   (if_u)
    );

    bin2ascii_word #(.SIGNED(1'b1), .BLANK_ZEROS(1'b1)) u_sgn (
        .clk   (clk),
        .reset (reset),
        .bus   (if_s)
    );

    bin2ascii_word #(.SIGNED(1'b1), .BLANK_ZEROS(1'b0)) u_nbz (
        .clk   (clk),
        .reset (reset),
        .bus   (if_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input bit sgn, input bit bz,
                                          input logic [7:0] v);
        int   n;
        int   m;
        int   first;
        bit   neg;
        byte  c[4];
        int   d[3];
        n = sgn ? int'($signed(v)) : int'(v);
        neg = (n < 0);
        m = neg ? -n : n;
        d[0] = m / 100;
        d[1] = (m / 10) % 10;
        d[2] = m % 10;
        for (int i = 0; i < 4; i++) c[i] = 8'h20;
        if (!bz) begin
            first = 0;
        end else if (m >= 100) begin
            first = 0;
        end else if (m >= 10) begin
            first = 1;
        end else begin
            first = 2;
        end
        for (int i = first; i < 3; i++) c[i+1] = byte'(8'h30 + d[i]);
        if (neg) c[first] = 8'h2D;
        return {c[0], c[1], c[2], c[3]};
    endfunction

    task automatic check_words(input string tag, input logic [7:0] v);
        chk({tag, "_uns"}, if_u.word, model(1'b0, 1'b1, v));
        chk({tag, "_sgn"}, if_s.word, model(1'b1, 1'b1, v));
        chk({tag, "_nbz"}, if_z.word, model(1'b1, 1'b0, v));
    endtask

    task automatic run_conv(input logic [7:0] v, input bit hold);
        int lows;
        int pulses;
        @(negedge clk);
        tb_valid = 1'b1;
        tb_value = v;
        @(posedge clk);
        #1;
        lows = 0;
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (!if_u.in_ready) lows++;
            if (if_u.word_valid) pulses++;
            if (hold && k < 8) begin
                tb_valid = 1'b1;
                tb_value = 8'($urandom);
            end else begin
                tb_valid = 1'b0;
            end
        end
        chk("ready_low_cycles", lows, 9);
        chk("early_pulse", pulses, 0);
        @(posedge clk);
        #1;
        chk("wv_after_fmt", {31'd0, if_u.word_valid}, 32'd1);
        chk("rdy_after_fmt", {31'd0, if_u.in_ready}, 32'd1);
        chk("busy_after_fmt", {31'd0, if_u.busy}, 32'd0);
        check_words("word", v);
        @(posedge clk);
        #1;
        chk("wv_drop", {31'd0, if_s.word_valid | if_u.word_valid
                        | if_z.word_valid}, 32'd0);
        check_words("word_hold", v);
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_word_u"}, if_u.word, 32'h20202020);
        chk({tag, "_word_s"}, if_s.word, 32'h20202020);
        chk({tag, "_word_z"}, if_z.word, 32'h20202020);
        chk({tag, "_rdy"}, {31'd0, if_u.in_ready}, 32'd1);
        chk({tag, "_wv"}, {31'd0, if_u.word_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, if_u.busy}, 32'd0);
    endtask

    logic [7:0] directed [11] = '{8'd0, 8'd7, 8'd42, 8'd100, 8'd255,
                                  8'hFF, 8'h80, 8'h7F, 8'hF6, 8'd5, 8'hFB};

    initial begin
        int pulses;
        n_checks = 0;
        n_errors = 0;
        tb_valid = 1'b0;
        tb_value = 8'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_reset("reset");

        foreach (directed[i]) run_conv(directed[i], 1'b0);
        for (int i = 0; i < 30; i++) run_conv(8'($urandom), 1'b0);
        run_conv(8'd123, 1'b1);
        run_conv(8'h9C, 1'b1);

        // Abort a conversion with reset sampled on E4.
        @(negedge clk);
        tb_valid = 1'b1;
        tb_value = 8'd77;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        chk("abort_busy", {31'd0, if_u.busy}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_reset("abort");
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (if_u.word_valid || if_s.word_valid || if_z.word_valid)
                pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        check_idle_reset("abort_after");

        run_conv(8'hFB, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
